// File: rtl/reg_wb_scheduler.sv
// Writeback scheduler: arbitrates two writeback requesters onto one register-file
// write port and keeps a per-register scoreboard of outstanding writes.
module reg_wb_scheduler #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [3:0]  issue_addr,
    output logic        issue_ready,
    input  logic [3:0]  source_a,
    input  logic [3:0]  source_b,
    output logic        hazard,
    input  logic        wb0_valid,
    input  logic [3:0]  wb0_addr,
    input  logic [15:0] wb0_data,
    output logic        wb0_ready,
    input  logic        wb1_valid,
    input  logic [3:0]  wb1_addr,
    input  logic [15:0] wb1_data,
    output logic        wb1_ready,
    output logic        reg_write,
    output logic [4:0]  dest_address,
    output logic [15:0] dest_val,
    output logic [15:0] pending
);

    logic [15:0] r_pending;
    logic        r_reg_write;
    logic [3:0]  r_dest_addr;
    logic [15:0] r_dest_val;
    logic        r_last_grant;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_transfer;
    logic        w_issue_xfer;
    logic [15:0] w_set_mask;
    logic [15:0] w_clr_mask;

    // Port 1 wins only when it is alone, or when round-robin says port 0 went last.
    assign w_grant1 = wb1_valid & (~wb0_valid | (RR_EN & ~r_last_grant));
    assign w_grant0 = wb0_valid & ~w_grant1;

    // Grants are masked by rst_n so nothing is offered while reset is held.
    assign wb0_ready   = rst_n & w_grant0;
    assign wb1_ready   = rst_n & w_grant1;
    assign w_transfer  = wb0_ready | wb1_ready;

    assign issue_ready  = rst_n & ~r_pending[issue_addr];
    assign w_issue_xfer = issue_valid & issue_ready;
    assign hazard       = r_pending[source_a] | r_pending[source_b];

    assign w_set_mask = w_issue_xfer ? (16'h0001 << issue_addr) : 16'h0000;
    assign w_clr_mask = r_reg_write  ? (16'h0001 << r_dest_addr) : 16'h0000;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= 16'h0000;
            r_reg_write  <= 1'b0;
            r_dest_addr  <= 4'h0;
            r_dest_val   <= 16'h0000;
            r_last_grant <= 1'b1;
        end else begin
            // Clear of the landing write is applied first so a same-edge set wins.
            r_pending   <= (r_pending & ~w_clr_mask) | w_set_mask;
            r_reg_write <= w_transfer;
            if (w_transfer) begin
                r_dest_addr  <= wb1_ready ? wb1_addr : wb0_addr;
                r_dest_val   <= wb1_ready ? wb1_data : wb0_data;
                r_last_grant <= wb1_ready;
            end
        end
    end

    assign reg_write    = r_reg_write;
    assign dest_address = {1'b0, r_dest_addr};
    assign dest_val     = r_dest_val;
    assign pending      = r_pending;

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed self-checking bench: a round-robin instance and a fixed-priority
// instance share all stimulus; expected values are hand-computed per scenario.
module tb_reg_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  issue_addr;
    logic [3:0]  source_a;
    logic [3:0]  source_b;
    logic        wb0_valid;
    logic [3:0]  wb0_addr;
    logic [15:0] wb0_data;
    logic        wb1_valid;
    logic [3:0]  wb1_addr;
    logic [15:0] wb1_data;

    logic        issue_ready, hazard, wb0_ready, wb1_ready, reg_write;
    logic [4:0]  dest_address;
    logic [15:0] dest_val, pending;

    logic        fp_issue_ready, fp_hazard, fp_wb0_ready, fp_wb1_ready, fp_reg_write;
    logic [4:0]  fp_dest_address;
    logic [15:0] fp_dest_val, fp_pending;

    int checks = 0;
    int errors = 0;

    reg_wb_scheduler #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .source_a(source_a), .source_b(source_b), .hazard(hazard),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .reg_write(reg_write), .dest_address(dest_address), .dest_val(dest_val), .pending(pending)
    );

    reg_wb_scheduler #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(fp_issue_ready),
        .source_a(source_a), .source_b(source_b), .hazard(fp_hazard),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(fp_wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(fp_wb1_ready),
        .reg_write(fp_reg_write), .dest_address(fp_dest_address), .dest_val(fp_dest_val),
        .pending(fp_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 1'b0; issue_addr = 4'h0;
        source_a = 4'h0; source_b = 4'h0;
        wb0_valid = 1'b0; wb0_addr = 4'h0; wb0_data = 16'h0000;
        wb1_valid = 1'b0; wb1_addr = 4'h0; wb1_data = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        wb0_valid = 1'b1; wb1_valid = 1'b1; issue_valid = 1'b1;
        #1;
        checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL reset_pending got %h exp 0000", pending); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %b exp 0", reg_write); end
        checks++; if (dest_address !== 5'd0 || dest_val !== 16'h0000) begin errors++; $display("FAIL reset_dest got %h/%h exp 00/0000", dest_address, dest_val); end
        checks++; if ({wb0_ready, wb1_ready, issue_ready} !== 3'b000) begin errors++; $display("FAIL reset_readies got %b exp 000", {wb0_ready, wb1_ready, issue_ready}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        wb0_valid = 1'b1; wb0_addr = 4'h6; wb0_data = 16'h0606;
        #1;
        checks++; if (wb0_ready !== 1'b1) begin errors++; $display("FAIL first_xfer_ready got %b exp 1", wb0_ready); end
        @(posedge clk); #1;
        checks++; if ({reg_write, dest_address, dest_val} !== {1'b1, 5'd6, 16'h0606}) begin errors++; $display("FAIL first_xfer_write got %b/%h/%h exp 1/06/0606", reg_write, dest_address, dest_val); end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks++; if (reg_write !== 1'b0 || dest_val !== 16'h0606) begin errors++; $display("FAIL idle_hold got %b/%h exp 0/0606", reg_write, dest_val); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 4'h3;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL basic_issue_ready got %b exp 1", issue_ready); end
        @(posedge clk); #1;
        checks++; if (pending !== 16'h0008) begin errors++; $display("FAIL basic_reserve got %h exp 0008", pending); end
        @(negedge clk);
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 4'h3; wb0_data = 16'h1234;
        @(posedge clk); #1;
        checks++; if ({reg_write, dest_address, dest_val} !== {1'b1, 5'd3, 16'h1234}) begin errors++; $display("FAIL basic_write got %b/%h/%h exp 1/03/1234", reg_write, dest_address, dest_val); end
        checks++; if (pending !== 16'h0008) begin errors++; $display("FAIL basic_pending_during_write got %h exp 0008", pending); end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks++; if (pending !== 16'h0000 || reg_write !== 1'b0) begin errors++; $display("FAIL basic_clear got %h/%b exp 0000/0", pending, reg_write); end
    endtask

    task automatic test_arbitration();
        logic [3:0]  exp_addr;
        logic [15:0] exp_data;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb0_valid = 1'b1; wb0_addr = 4'h1; wb0_data = 16'h1000 + 16'(i);
            wb1_valid = 1'b1; wb1_addr = 4'h2; wb1_data = 16'h2000 + 16'(i);
            #1;
            checks++; if ({wb0_ready, wb1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d got %b%b", i, wb0_ready, wb1_ready); end
            checks++; if ({fp_wb0_ready, fp_wb1_ready} !== 2'b10) begin errors++; $display("FAIL fp_grant%0d got %b%b exp 10", i, fp_wb0_ready, fp_wb1_ready); end
            exp_addr = (i % 2 == 0) ? 4'h1 : 4'h2;
            exp_data = (i % 2 == 0) ? 16'h1000 + 16'(i) : 16'h2000 + 16'(i);
            @(posedge clk); #1;
            checks++; if ({reg_write, dest_address, dest_val} !== {1'b1, 1'b0, exp_addr, exp_data}) begin errors++; $display("FAIL rr_write%0d got %b/%h/%h exp 1/%h/%h", i, reg_write, dest_address, dest_val, exp_addr, exp_data); end
            checks++; if ({fp_reg_write, fp_dest_address, fp_dest_val} !== {1'b1, 5'd1, 16'h1000 + 16'(i)}) begin errors++; $display("FAIL fp_write%0d got %b/%h/%h", i, fp_reg_write, fp_dest_address, fp_dest_val); end
        end
        checks++; if (pending !== 16'h0000) begin errors++; $display("FAIL nonpending_write got %h exp 0000", pending); end
        @(negedge clk);
        wb0_valid = 1'b0;
        #1;
        checks++; if ({fp_wb0_ready, fp_wb1_ready} !== 2'b01) begin errors++; $display("FAIL fp_single_wb1 got %b%b exp 01", fp_wb0_ready, fp_wb1_ready); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_hazard();
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 4'h5;
        @(posedge clk); #1;
        checks++; if (pending !== 16'h0020) begin errors++; $display("FAIL hz_reserve got %h exp 0020", pending); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL hz_waw_stall got %b exp 0", issue_ready); end
        @(negedge clk);
        source_a = 4'h5; source_b = 4'h0;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_src_a got %b exp 1", hazard); end
        source_a = 4'h0; source_b = 4'h5;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_src_b got %b exp 1", hazard); end
        wb1_valid = 1'b1; wb1_addr = 4'h5; wb1_data = 16'h5555;
        @(posedge clk); #1;
        checks++; if ({reg_write, dest_address, issue_ready, hazard} !== {1'b1, 5'd5, 1'b0, 1'b1}) begin errors++; $display("FAIL hz_landing got %b/%h/%b/%b exp 1/05/0/1", reg_write, dest_address, issue_ready, hazard); end
        @(negedge clk);
        wb1_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({issue_ready, hazard} !== 2'b10) begin errors++; $display("FAIL hz_released got %b%b exp 10", issue_ready, hazard); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 4'h7;
        @(negedge clk);
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 4'h7; wb0_data = 16'h7777;
        @(negedge clk);
        wb0_valid = 1'b0;
        issue_valid = 1'b1; issue_addr = 4'h2;
        #1;
        checks++; if ({reg_write, dest_address, pending} !== {1'b1, 5'd7, 16'h0080}) begin errors++; $display("FAIL sim_setup got %b/%h/%h exp 1/07/0080", reg_write, dest_address, pending); end
        @(posedge clk); #1;
        checks++; if (pending !== 16'h0004) begin errors++; $display("FAIL sim_set_clear got %h exp 0004", pending); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            issue_valid = 1'b1; issue_addr = 4'(i);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 4'h9; wb0_data = 16'hBEEF;
        @(posedge clk); #1;
        checks++; if ({reg_write, dest_val, pending} !== {1'b1, 16'hBEEF, 16'h00F0}) begin errors++; $display("FAIL mid_setup got %b/%h/%h exp 1/BEEF/00F0", reg_write, dest_val, pending); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({reg_write, dest_address, dest_val, pending} !== 38'd0) begin errors++; $display("FAIL mid_async got %b/%h/%h/%h exp all zero", reg_write, dest_address, dest_val, pending); end
        checks++; if (wb0_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset got %b exp 0", wb0_ready); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({reg_write, pending} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL mid_after_release got %b/%h exp 0/0000", reg_write, pending); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arbitration();
        test_hazard();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_scheduler.md
REG_WB_SCHEDULER -- requirements
Module: reg_wb_scheduler

Interface
REQ-001 Parameter: RR_EN, 1, 1 = round-robin between writeback ports; 0 = fixed priority, port 0 wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 issue_valid  input  1  instruction issue requests reservation of a destination register.
REQ-005 issue_addr  input  4  destination register being reserved.
REQ-006 issue_ready  output  1  reservation accepted this cycle when high with issue_valid.
REQ-007 source_a, source_b  input  4 each  source registers of the issuing instruction.
REQ-008 hazard  output  1  a source register has an outstanding write.
REQ-009 wb0_valid, wb0_addr[3:0], wb0_data[15:0]  input  writeback requester 0 (ALU).
REQ-010 wb0_ready  output  1  requester 0 granted this cycle.
REQ-011 wb1_valid, wb1_addr[3:0], wb1_data[15:0], wb1_ready  as REQ-009/010  writeback requester 1 (load unit).
REQ-012 reg_write  output  1  register-file write enable.
REQ-013 dest_address  output  5  register-file write address; bit 4 always 0.
REQ-014 dest_val  output  16  register-file write data.
REQ-015 pending  output  16  scoreboard, bit n = register n has an outstanding write.

Function
REQ-016 Handshake: a transfer on a port occurs in any cycle where valid and ready are both high; ready is combinational from valid inputs and arbitration state.
REQ-017 At most one of wb0_ready/wb1_ready shall be high in any cycle; ready shall be low on a port whose valid is low.
REQ-018 Single requester valid: that requester is granted in the same cycle.
REQ-019 Both valid, RR_EN=1: grant the port not granted in the most recent transfer (last_grant); RR_EN=0: grant port 0.
REQ-020 last_grant updates only on a writeback transfer; reset value 1 (port 0 wins first contention).
REQ-021 Write latency one cycle: after a transfer at edge k, during cycle k+1 reg_write=1, dest_address={0,addr}, dest_val=data.
REQ-022 Cycle with no transfer: next cycle reg_write=0; dest_address and dest_val hold previous values.
REQ-023 Back-to-back transfers sustain one write per cycle with no bubble.
REQ-024 Scoreboard set: on issue transfer (issue_valid & issue_ready), pending[issue_addr] set at that edge.
REQ-025 Scoreboard clear: at an edge where reg_write=1, pending[dest_address[3:0]] cleared (register file updated at same edge).
REQ-026 issue_ready = ~pending[issue_addr]; no second reservation of a pending register (WAW stall).
REQ-027 hazard = pending[source_a] | pending[source_b], combinational, independent of issue_valid.
REQ-028 Simultaneous set and clear of different registers in one edge: both applied.
REQ-029 Writeback to a non-pending register: write performed normally; pending unchanged.
REQ-030 Clear and new reservation of the same register cannot coincide (REQ-026); in the cycle after the clear, issue_ready for that register is high.

Reset
REQ-031 rst_n low asynchronously forces: pending=0, reg_write=0, dest_address=0, dest_val=0, last_grant=1.
REQ-032 Reset mid-operation discards any in-flight write and all reservations; while rst_n low, wb0_ready=wb1_ready=0 and issue_ready=0.
REQ-033 First transfer accepted at first rising edge with rst_n high.

Verification
REQ-034 Reserve r3, then wb0 writes r3=0x1234 -> pending[3]=1 one cycle after issue; reg_write=1, dest_address=3, dest_val=0x1234 one cycle after wb transfer; pending[3]=0 the following cycle.
REQ-035 RR_EN=1, wb0 and wb1 valid for 4 cycles after reset -> grants 0,1,0,1; writes appear in that order on consecutive cycles.
REQ-036 RR_EN=0, both valid 3 cycles -> wb0 granted all 3, wb1_ready stays 0.
REQ-037 r5 pending, issue_valid with issue_addr=5 -> issue_ready=0; source_a=5 -> hazard=1; after wb to r5 lands, issue_ready=1 and hazard=0.
REQ-038 Same-edge reserve r2 and reg_write clear of r7 -> pending[2]=1, pending[7]=0 next cycle.
REQ-039 rst_n pulsed low during cycle with reg_write=1 and pending=0x00F0 -> outputs zero immediately, pending=0, no write after release.
